// File: rtl/ptr_mem_port_if.sv
// ptr_mem_port_if
// Data-memory bus used by the pointer load/store sequencer.
//   mem_addr  : 16-bit byte address, driven by the master
//   mem_wdata : store data, driven by the master
//   mem_re    : read enable, driven by the master
//   mem_we    : write enable, driven by the master
//   mem_rdata : read data, driven by the memory, valid with mem_ready
//   mem_ready : access-complete indication, driven by the memory
// The master modport is the sequencer side, the slave modport is the memory.

interface ptr_mem_port_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_re,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_re,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/ptr_mem_port.sv
// ptr_mem_port
// Load/store sequencer for the register-file pointer pairs. A 16-bit pointer
// taken from an even/odd register pair addresses one byte access on the data
// memory bus; afterwards the result is returned to the register file as a
// load write-back and/or a post-increment / pre-decrement pulse on the pair.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   req_i         : start-access strobe, only looked at while idle
//   op_store_i    : 1 = store, 0 = load
//   mode_i        : 00 plain, 01 post-increment, 10 pre-decrement, 11 plain
//   ptr_sel_i     : even register index of the pointer pair (bit0 ignored)
//   ptr_lo_i/hi_i : pointer bytes read from the pair
//   dst_sel_i     : load destination register
//   st_data_i     : store data
//   mem           : data-memory bus (master side)
//   rf_sel_o/rf_in_o/rf_we_o : register-file write port for loads
//   rf_ptr_o/rf_inc_o/rf_dec_o : pair select and pointer update pulses
//   busy_o        : access in progress
//   done_o        : one-cycle pulse on successful completion
//   err_o         : one-cycle pulse when the access times out

module ptr_mem_port #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  op_store_i,
    input  logic [1:0]            mode_i,
    input  logic [3:0]            ptr_sel_i,
    input  logic [7:0]            ptr_lo_i,
    input  logic [7:0]            ptr_hi_i,
    input  logic [3:0]            dst_sel_i,
    input  logic [7:0]            st_data_i,
    ptr_mem_port_if.master        mem,
    output logic [3:0]            rf_sel_o,
    output logic [3:0]            rf_ptr_o,
    output logic [7:0]            rf_in_o,
    output logic                  rf_we_o,
    output logic                  rf_inc_o,
    output logic                  rf_dec_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_t;

    localparam logic [1:0] MODE_POSTINC = 2'b01;
    localparam logic [1:0] MODE_PREDEC  = 2'b10;

    state_t           state_q, state_d;
    logic             store_q, store_d;
    logic [1:0]       mode_q,  mode_d;
    logic [3:0]       pair_q,  pair_d;
    logic [3:0]       dst_q,   dst_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [15:0]      ea_q,    ea_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic timeoutHit;
    logic conflict;

    // The counter holds the number of wait cycles already spent in ACCESS;
    // a TIMEOUT of zero means wait forever.
    assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // A load whose destination is one half of the pointer pair owns the
    // register-file write; the pointer update is dropped so the loaded value
    // is not immediately modified.
    assign conflict = !store_q && (dst_q[3:1] == pair_q[3:1]);

    // State and datapath registers. Reset clears everything so an aborted
    // access leaves no stale request behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            mode_q  <= 2'b00;
            pair_q  <= 4'h0;
            dst_q   <= 4'h0;
            wdata_q <= 8'h00;
            ea_q    <= 16'h0000;
            rdata_q <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            mode_q  <= mode_d;
            pair_q  <= pair_d;
            dst_q   <= dst_d;
            wdata_q <= wdata_d;
            ea_q    <= ea_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The whole request is captured at acceptance so the
    // control unit is free to change its inputs while the access runs; the
    // pre-decrement is applied to the address here, before the bus cycle.
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        mode_d  = mode_q;
        pair_d  = pair_q;
        dst_d   = dst_q;
        wdata_d = wdata_q;
        ea_d    = ea_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    store_d = op_store_i;
                    mode_d  = mode_i;
                    pair_d  = ptr_sel_i & 4'b1110;
                    dst_d   = dst_sel_i;
                    wdata_d = st_data_i;
                    if (mode_i == MODE_PREDEC) begin
                        ea_d = {ptr_hi_i, ptr_lo_i} - 16'd1;
                    end else begin
                        ea_d = {ptr_hi_i, ptr_lo_i};
                    end
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem.mem_ready) begin
                    if (!store_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = WB;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Everything is a function of the current state so the
    // bus drops the moment reset forces the state back to IDLE.
    always_comb begin
        mem.mem_addr  = 16'h0000;
        mem.mem_wdata = 8'h00;
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        rf_sel_o      = 4'h0;
        rf_ptr_o      = 4'h0;
        rf_in_o       = 8'h00;
        rf_we_o       = 1'b0;
        rf_inc_o      = 1'b0;
        rf_dec_o      = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        err_o         = 1'b0;

        case (state_q)
            ACCESS: begin
                busy_o        = 1'b1;
                mem.mem_addr  = ea_q;
                mem.mem_wdata = wdata_q;
                mem.mem_re    = !store_q;
                mem.mem_we    = store_q;
                err_o         = !mem.mem_ready && timeoutHit;
            end
            WB: begin
                busy_o   = 1'b1;
                done_o   = 1'b1;
                rf_ptr_o = pair_q;
                if (!store_q) begin
                    rf_we_o  = 1'b1;
                    rf_sel_o = dst_q;
                    rf_in_o  = rdata_q;
                end
                rf_inc_o = (mode_q == MODE_POSTINC) && !conflict;
                rf_dec_o = (mode_q == MODE_PREDEC) && !conflict;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ptr_mem_port.sv
// tb_ptr_mem_port
// Scoreboard bench for ptr_mem_port. Each access pushes its expected memory
// address/data, access length and register-file results; a negedge monitor
// checks the bus every cycle and pops an entry on every done/err pulse.

module tb_ptr_mem_port;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        opStore;
    logic [1:0]  mode;
    logic [3:0]  ptrSel;
    logic [7:0]  ptrLo;
    logic [7:0]  ptrHi;
    logic [3:0]  dstSel;
    logic [7:0]  stData;
    logic [3:0]  rfSel;
    logic [3:0]  rfPtr;
    logic [7:0]  rfIn;
    logic        rfWe;
    logic        rfInc;
    logic        rfDec;
    logic        busy;
    logic        done;
    logic        err;

    ptr_mem_port_if mif ();

    ptr_mem_port #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .op_store_i (opStore),
        .mode_i     (mode),
        .ptr_sel_i  (ptrSel),
        .ptr_lo_i   (ptrLo),
        .ptr_hi_i   (ptrHi),
        .dst_sel_i  (dstSel),
        .st_data_i  (stData),
        .mem        (mif),
        .rf_sel_o   (rfSel),
        .rf_ptr_o   (rfPtr),
        .rf_in_o    (rfIn),
        .rf_we_o    (rfWe),
        .rf_inc_o   (rfInc),
        .rf_dec_o   (rfDec),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    typedef struct {
        bit          isErr;
        bit          store;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          hold;
        bit          expWe;
        logic [3:0]  expSel;
        logic [7:0]  expIn;
        logic [3:0]  expPtr;
        bit          expInc;
        bit          expDec;
    } expRec_t;

    expRec_t expQ[$];
    int      testsRun  = 0;
    int      failCount = 0;
    int      accCycles = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        testsRun++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected results are derived from the request alone: address, access
    // length and what the register file should see at write-back.
    function automatic expRec_t makeExp(input bit st, input logic [1:0] md, input logic [3:0] sel,
                                        input logic [15:0] ptr, input logic [3:0] dst,
                                        input logic [7:0] sd, input int waits, input logic [7:0] rd);
        expRec_t e;
        logic [3:0] pair;
        bit         clash;
        pair     = {sel[3:1], 1'b0};
        clash    = !st && ((dst == pair) || (dst == {sel[3:1], 1'b1}));
        e.isErr  = 1'b0;
        e.store  = st;
        e.addr   = (md == 2'b10) ? ptr - 16'd1 : ptr;
        e.wdata  = sd;
        e.hold   = waits + 1;
        e.expWe  = !st;
        e.expSel = dst;
        e.expIn  = rd;
        e.expPtr = pair;
        e.expInc = (md == 2'b01) && !clash;
        e.expDec = (md == 2'b10) && !clash;
        return e;
    endfunction

    task automatic driveReq(input bit st, input logic [1:0] md, input logic [3:0] sel,
                            input logic [15:0] ptr, input logic [3:0] dst, input logic [7:0] sd);
        req     = 1'b1;
        opStore = st;
        mode    = md;
        ptrSel  = sel;
        ptrHi   = ptr[15:8];
        ptrLo   = ptr[7:0];
        dstSel  = dst;
        stData  = sd;
    endtask

    // One complete access with a memory that answers after 'waits' cycles.
    task automatic applyStimulus(input bit st, input logic [1:0] md, input logic [3:0] sel,
                                 input logic [15:0] ptr, input logic [3:0] dst,
                                 input logic [7:0] sd, input int waits, input logic [7:0] rd);
        expQ.push_back(makeExp(st, md, sel, ptr, dst, sd, waits, rd));
        mif.mem_ready = 1'b0;
        mif.mem_rdata = rd;
        driveReq(st, md, sel, ptr, dst, sd);
        tick();
        req = 1'b0;
        checkOutput("busy_in_access", 64'(busy), 64'(1));
        mif.mem_ready = (waits == 0);
        for (int i = 1; i <= waits; i++) begin
            tick();
            mif.mem_ready = (i == waits);
        end
        tick();
        mif.mem_ready = 1'b0;
        tick();
        checkOutput("busy_after_done", 64'(busy), 64'(0));
    endtask

    // Access whose memory never answers; expects an err pulse and no
    // register-file activity.
    task automatic applyTimeout(input logic [15:0] ptr);
        expRec_t e;
        e        = makeExp(1'b0, 2'b01, 4'h6, ptr, 4'h1, 8'h00, TIMEOUT, 8'h00);
        e.isErr  = 1'b1;
        e.expWe  = 1'b0;
        e.expInc = 1'b0;
        e.expDec = 1'b0;
        expQ.push_back(e);
        mif.mem_ready = 1'b0;
        driveReq(1'b0, 2'b01, 4'h6, ptr, 4'h1, 8'h00);
        tick();
        req = 1'b0;
        repeat (TIMEOUT + 1) tick();
        checkOutput("busy_after_err", 64'(busy), 64'(0));
    endtask

    // Negedge monitor: bus contents every access cycle, completion results
    // against the scoreboard, and quiet register-file outputs otherwise.
    always @(negedge clk) begin
        expRec_t e;
        if (rst) begin
            accCycles = 0;
        end else begin
            checkOutput("re_we_exclusive", 64'(mif.mem_re & mif.mem_we), 64'(0));
            if (mif.mem_re || mif.mem_we) begin
                accCycles++;
                if (expQ.size() > 0) begin
                    checkOutput("mem_addr", 64'(mif.mem_addr), 64'(expQ[0].addr));
                    checkOutput("mem_we", 64'(mif.mem_we), 64'(expQ[0].store));
                    if (expQ[0].store) begin
                        checkOutput("mem_wdata", 64'(mif.mem_wdata), 64'(expQ[0].wdata));
                    end
                end
            end
            if (done || err) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_completion", 64'(done | err), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done", 64'(done), 64'(!e.isErr));
                    checkOutput("err", 64'(err), 64'(e.isErr));
                    checkOutput("access_cycles", 64'(accCycles), 64'(e.hold));
                    checkOutput("busy_at_end", 64'(busy), 64'(1));
                    checkOutput("rf_we", 64'(rfWe), 64'(e.expWe));
                    checkOutput("rf_inc", 64'(rfInc), 64'(e.expInc));
                    checkOutput("rf_dec", 64'(rfDec), 64'(e.expDec));
                    if (!e.isErr) begin
                        checkOutput("rf_ptr", 64'(rfPtr), 64'(e.expPtr));
                    end
                    if (e.expWe) begin
                        checkOutput("rf_sel", 64'(rfSel), 64'(e.expSel));
                        checkOutput("rf_in", 64'(rfIn), 64'(e.expIn));
                    end
                end
                accCycles = 0;
            end else begin
                checkOutput("rf_quiet", 64'({rfWe, rfInc, rfDec}), 64'(0));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        req           = 1'b0;
        opStore       = 1'b0;
        mode          = 2'b00;
        ptrSel        = 4'h0;
        ptrLo         = 8'h00;
        ptrHi         = 8'h00;
        dstSel        = 4'h0;
        stData        = 8'h00;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 8'h00;

        repeat (2) tick();
        @(negedge clk);
        checkOutput("reset_outputs",
                    64'({mif.mem_addr, mif.mem_wdata, mif.mem_re, mif.mem_we, rfSel, rfPtr,
                         rfIn, rfWe, rfInc, rfDec, busy, done, err}), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 2'b01, 4'h2, 16'h12FF, 4'h5, 8'h00, 0, 8'hA5);
        applyStimulus(1'b1, 2'b10, 4'h5, 16'h0000, 4'h0, 8'h3C, 3, 8'h00);
        applyStimulus(1'b0, 2'b01, 4'h2, 16'h0100, 4'h3, 8'h00, 1, 8'h77);
        applyStimulus(1'b0, 2'b10, 4'h2, 16'h4000, 4'h2, 8'h00, 2, 8'h19);
        applyStimulus(1'b0, 2'b11, 4'hA, 16'h8000, 4'h7, 8'h00, 2, 8'hC3);
        applyStimulus(1'b1, 2'b01, 4'hC, 16'hFFFF, 4'hC, 8'h5E, 0, 8'h00);

        $display("[TB] timeout");
        applyTimeout(16'hBEEF);

        $display("[TB] reset during store");
        expQ.push_back(makeExp(1'b1, 2'b00, 4'h6, 16'h4444, 4'h0, 8'h99, 10, 8'h00));
        driveReq(1'b1, 2'b00, 4'h6, 16'h4444, 4'h0, 8'h99);
        tick();
        req = 1'b0;
        tick();
        checkOutput("we_before_reset", 64'(mif.mem_we), 64'(1));
        #2 rst = 1'b1;
        #1;
        checkOutput("we_in_reset", 64'(mif.mem_we), 64'(0));
        checkOutput("busy_in_reset", 64'(busy), 64'(0));
        tick();
        rst = 1'b0;
        expQ.delete();
        tick();
        applyStimulus(1'b1, 2'b00, 4'h6, 16'h4444, 4'h0, 8'h99, 1, 8'h00);

        $display("[TB] req held high");
        expQ.push_back(makeExp(1'b0, 2'b01, 4'h8, 16'h2000, 4'h1, 8'h00, 0, 8'h5A));
        expQ.push_back(makeExp(1'b0, 2'b01, 4'h8, 16'h2000, 4'h1, 8'h00, 0, 8'h5A));
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 8'h5A;
        driveReq(1'b0, 2'b01, 4'h8, 16'h2000, 4'h1, 8'h00);
        tick();
        tick();
        tick();
        checkOutput("held_req_gap", 64'(busy), 64'(0));
        tick();
        checkOutput("held_req_second", 64'(busy), 64'(1));
        tick();
        tick();
        req           = 1'b0;
        mif.mem_ready = 1'b0;
        tick();
        checkOutput("held_req_released", 64'(busy), 64'(0));

        $display("[TB] random accesses");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 16'($urandom),
                          4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                          $urandom_range(0, 3), 8'($urandom_range(0, 255)));
        end

        repeat (3) tick();
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
